// File: rtl/tx_phy_gen_if.sv
// Frame-control and TxFIFO handshake bundle for tx_phy_gen.
// The slave side is the line generator; the master is the controller/FIFO.
interface tx_phy_gen_if #(
    parameter int NUM_PHY = 32
);
    logic               tx_phy_start;
    logic [NUM_PHY-1:0] tx_phy_sel;
    logic               tx_phy_done;
    logic               tx_phy_busy;
    logic [31:0]        tx_dout;
    logic               tx_rd_en;

    modport master (
        output tx_phy_start,
        output tx_phy_sel,
        output tx_dout,
        input  tx_phy_done,
        input  tx_phy_busy,
        input  tx_rd_en
    );

    modport slave (
        input  tx_phy_start,
        input  tx_phy_sel,
        input  tx_dout,
        output tx_phy_done,
        output tx_phy_busy,
        output tx_rd_en
    );
endinterface

// File: rtl/tx_phy_gen.sv
// Frame transmitter: pops a header and payload from the TxFIFO, then
// streams payload and nonce words on RZ-coded differential lanes.
module tx_phy_gen #(
    parameter int NUM_PHY  = 32,
    parameter int HDR_LEN  = 4,
    parameter int DATA_LEN = 23,
    parameter int TICK_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_flush,
    input  logic [TICK_W-1:0]  reg_tick,
    input  logic [31:0]        reg_nonce_max,
    tx_phy_gen_if.slave        phy,
    output logic               task_id_vld,
    output logic [NUM_PHY-1:0] rx_phy_sel,
    output logic [31:0]        task_id_h,
    output logic [31:0]        task_id_l,
    output logic [31:0]        reg_tout,
    output logic [NUM_PHY-1:0] TX_P,
    output logic [NUM_PHY-1:0] TX_N
);
    localparam int HW = $clog2(HDR_LEN + 1);
    localparam int DW = $clog2(DATA_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        TASK,
        HASH,
        NONCE
    } state_t;

    state_t state, state_nx;

    logic [HW-1:0]     hdr_cnt;
    logic [DW-1:0]     word_cnt;
    logic [TICK_W-1:0] tick_len;
    logic [TICK_W-1:0] tick_cnt;
    logic [4:0]        bit_cnt;
    logic              half;
    logic              loading;
    logic [31:0]       shreg;
    logic [31:0]       step;
    logic [32:0]       acc;
    logic [31:0]       nonce_k;

    logic        tick;
    logic        word_end;
    logic        hash_last;
    logic        nonce_last;
    logic [31:0] step_eff;
    logic [32:0] acc_nx;
    logic        rd_en;
    logic        done;
    logic        p_bit;
    logic        n_bit;

    assign tick       = (tick_cnt == tick_len);
    assign word_end   = tick && half && !loading
                        && (bit_cnt == 5'd31);
    assign hash_last  = (word_cnt == DW'(DATA_LEN - 1));
    assign step_eff   = (step == 32'd0) ? 32'd1 : step;
    assign acc_nx     = acc + {1'b0, step_eff};
    assign nonce_last = acc_nx[32]
                        || ((reg_nonce_max != 32'd0)
                            && (nonce_k == reg_nonce_max));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (phy.tx_phy_start) state_nx = TASK;
            end
            TASK: begin
                rd_en = 1'b1;
                if (hdr_cnt == HW'(HDR_LEN - 1)) state_nx = HASH;
            end
            HASH: begin
                if (loading) begin
                    rd_en = 1'b1;
                end else if (word_end) begin
                    if (hash_last) state_nx = NONCE;
                    else           rd_en    = 1'b1;
                end
            end
            NONCE: begin
                if (word_end && nonce_last) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle start.
        if (reg_flush || rst) begin
            state_nx = IDLE;
            rd_en    = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            task_id_vld <= 1'b0;
            rx_phy_sel  <= '0;
            task_id_h   <= '0;
            task_id_l   <= '0;
            reg_tout    <= '0;
            step        <= '0;
            tick_len    <= '0;
            tick_cnt    <= '0;
            hdr_cnt     <= '0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            half        <= 1'b0;
            loading     <= 1'b0;
            shreg       <= '0;
            acc         <= '0;
            nonce_k     <= '0;
        end else begin
            task_id_vld <= 1'b0;
            tick_cnt    <= '0;
            if (state == IDLE && state_nx == TASK) begin
                rx_phy_sel <= phy.tx_phy_sel;
                tick_len   <= reg_tick;
                hdr_cnt    <= '0;
            end
            if (state == TASK && rd_en) begin
                hdr_cnt <= hdr_cnt + 1'b1;
                case (hdr_cnt)
                    HW'(0):  task_id_h <= phy.tx_dout;
                    HW'(1):  task_id_l <= phy.tx_dout;
                    HW'(2):  step      <= phy.tx_dout;
                    HW'(3):  reg_tout  <= phy.tx_dout;
                    default: ;
                endcase
                task_id_vld <= (state_nx == HASH);
                loading     <= 1'b1;
            end
            if (state == HASH || state == NONCE) begin
                if (loading) begin
                    loading  <= 1'b0;
                    shreg    <= phy.tx_dout;
                    word_cnt <= '0;
                    bit_cnt  <= '0;
                    half     <= 1'b0;
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        half <= ~half;
                        if (half) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            // Next word is fetched exactly as the last spacer ends.
                            if (bit_cnt == 5'd31) begin
                                if (state == HASH && !hash_last) begin
                                    word_cnt <= word_cnt + 1'b1;
                                    shreg    <= phy.tx_dout;
                                end else if (state == HASH) begin
                                    shreg   <= step_eff;
                                    acc     <= {1'b0, step_eff};
                                    nonce_k <= 32'd1;
                                end else begin
                                    shreg   <= acc_nx[31:0];
                                    acc     <= acc_nx;
                                    nonce_k <= nonce_k + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        p_bit = 1'b1;
        n_bit = 1'b1;
        unique case (state)
            IDLE: begin
                p_bit = 1'b1;
                n_bit = 1'b1;
            end
            TASK: begin
                p_bit = 1'b0;
                n_bit = 1'b0;
            end
            HASH, NONCE: begin
                p_bit = !(loading || half) && shreg[0];
                n_bit = !(loading || half) && !shreg[0];
            end
            default: ;
        endcase
    end

    assign TX_P = ({NUM_PHY{p_bit}} & rx_phy_sel) | ~rx_phy_sel;
    assign TX_N = ({NUM_PHY{n_bit}} & rx_phy_sel) | ~rx_phy_sel;

    assign phy.tx_rd_en    = rd_en;
    assign phy.tx_phy_done = done;
    assign phy.tx_phy_busy = (state != IDLE);
endmodule

// File: doc/tx_phy_gen.md
TX_PHY_GEN -- requirements
Module: tx_phy_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_PHY, 32, number of TX lane pairs;
  HDR_LEN, 4, header words popped per frame (minimum 4);
  DATA_LEN, 23, payload words per frame;
  TICK_W, 8, width of the bit-period register.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock;
  rst  in  1  synchronous active-high reset;
  reg_flush  in  1  abort the current frame;
  reg_tick  in  TICK_W  half-symbol length minus 1;
  reg_nonce_max  in  32  nonce word limit, 0 = unlimited;
  tx_phy_start  in  1  start-frame pulse;
  tx_phy_sel  in  NUM_PHY  lane select;
  tx_phy_done  out  1  frame-complete pulse;
  tx_phy_busy  out  1  not IDLE;
  tx_dout  in  32  TxFIFO show-ahead data;
  tx_rd_en  out  1  TxFIFO pop;
  task_id_vld  out  1  header-valid pulse;
  rx_phy_sel  out  NUM_PHY  latched lane select;
  task_id_h  out  32  header word 0;
  task_id_l  out  32  header word 1;
  reg_tout  out  32  header word 3;
  TX_P  out  NUM_PHY  positive lines;
  TX_N  out  NUM_PHY  negative lines.
REQ-003 One clock, clk; rst is synchronous and active-high; no other clock or asynchronous reset.

Function
REQ-004 FSM states: IDLE, TASK, HASH, NONCE. Transitions:
  IDLE->TASK on tx_phy_start;
  TASK->HASH after HDR_LEN pops;
  HASH->NONCE after the last symbol of payload word DATA_LEN-1;
  NONCE->IDLE after the last symbol of the final nonce word.
REQ-005 On IDLE->TASK, latch tx_phy_sel into rx_phy_sel and reg_tick into an internal tick_len; later changes to either input have no effect until the next frame.
REQ-006 tx_phy_start outside IDLE is ignored.
REQ-007 TASK: tx_rd_en is high for exactly HDR_LEN consecutive cycles, and tx_dout is captured in the same cycle as each pop.
  Pop 0 -> task_id_h; pop 1 -> task_id_l; pop 2 -> step; pop 3 -> reg_tout; pops 4 and later are discarded.
REQ-008 task_id_vld is a one-cycle pulse in the cycle after the last header pop.
REQ-009 Tick counter: runs only in HASH/NONCE, counts 0..tick_len and wraps; tick is asserted when count==tick_len; the counter is cleared in all other states.
REQ-010 Line code, per bit, LSB first:
  data half: {P,N} = {b,~b} for one tick period;
  spacer half: {P,N} = 00 for one tick period.
  One bit therefore takes 2*(tick_len+1) cycles.
REQ-011 From the IDLE->TASK transition until the first data half, lines are held at 00 (start condition); in IDLE, lines are 11.
REQ-012 Lanes with rx_phy_sel[i]=0 drive {TX_P[i],TX_N[i]}=11 at all times.
REQ-013 HASH: each payload word is popped with a one-cycle tx_rd_en pulse, before its first data half, then shifted out 32 bits.
  Total payload pops per frame: exactly DATA_LEN.
  No FIFO pops occur in NONCE.
REQ-014 NONCE: word k (k=1,2,...) carries k*step, computed with 33-bit arithmetic. step==0 is treated as 1.
REQ-015 The final nonce word is the last k for which k*step <= 0xFFFFFFFF, or k==reg_nonce_max when reg_nonce_max is nonzero, whichever comes first.
REQ-016 tx_phy_done is a one-cycle pulse on NONCE->IDLE; lines return to 11 in the following cycle.
REQ-017 tx_phy_busy = (state != IDLE).
REQ-018 reg_flush, in any state: next state IDLE, lines 11, tx_rd_en low, no tx_phy_done, no further pops. Flush has priority over start in the same cycle.
REQ-019 Simultaneous tick and last-symbol end: the state transition wins; no extra symbol is emitted.

Reset
REQ-020 rst forces, at the next edge: state IDLE; TX_P/TX_N all 1; tx_rd_en, tx_phy_done, task_id_vld and tx_phy_busy 0; rx_phy_sel 0; task_id_h, task_id_l, reg_tout and step 0; tick counter 0.
REQ-021 rst asserted mid-frame behaves as REQ-020, with no done pulse; the FIFO is not drained.

Verification
REQ-022 Pulse tx_phy_start with tx_phy_sel=0x1 and header words 0xAAAA0001, 0xBBBB0002, 0x80000000, 0x00000064 -> task_id_vld pulses once; task_id_h=0xAAAA0001; task_id_l=0xBBBB0002; reg_tout=0x64.
REQ-023 reg_tick=1, first payload word 0x00000005 -> lane 0 shows:
  bit 0: {1,0} for 2 cycles, then {0,0} for 2 cycles;
  bit 1: {0,1}, then {0,0};
  bit 2: {1,0}, then {0,0};
  remaining 29 bits: {0,1} pattern.
  Lanes 1..NUM_PHY-1 stay at 11 throughout.
REQ-024 step=0x80000000, reg_nonce_max=0 -> exactly one nonce word, 0x80000000, then tx_phy_done pulses once and the lines return to 11.
REQ-025 step=1, reg_nonce_max=3 -> nonce words 1, 2, 3 followed by tx_phy_done; total FIFO pops = HDR_LEN+DATA_LEN.
REQ-026 reg_flush asserted during payload word 5 -> lines go to 11 at the next edge, no further tx_rd_en, no tx_phy_done; a subsequent tx_phy_start runs a complete frame.
REQ-027 rst asserted during NONCE -> all outputs match REQ-020 at the next edge; tx_phy_start applied in the same cycle as rst is ignored.
